// File: rtl/i2s_tdm_slave_tx_if.sv
// Frame hand-off bus into the I2S/TDM slave transmitter: one NUM_CHAN*DAT_WDTH frame per valid/ready transfer.
interface i2s_tdm_slave_tx_if #(
    parameter int unsigned DAT_WDTH = 24,
    parameter int unsigned NUM_CHAN = 2
);
    logic [NUM_CHAN*DAT_WDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tdm_slave_tx.sv
// I2S/TDM slave transmitter: oversamples external sck/ws on clk and shifts one frame per ws falling edge.
// Defining I2S_TX_UFLOW_CNT_EN adds the saturating underflow counter output uflow_cnt.
module i2s_tdm_slave_tx #(
    parameter int unsigned DAT_WDTH = 24,
    parameter int unsigned SYS_WDTH = 32,
    parameter int unsigned NUM_CHAN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sck,
    input  logic               ws,
    output logic               sd,
    i2s_tdm_slave_tx_if.slave  s_if,
    input  logic               mute,
    output logic               underflow,
    output logic               frame_err
`ifdef I2S_TX_UFLOW_CNT_EN
    ,
    output logic [15:0]        uflow_cnt
`endif
);
    localparam int unsigned FRM_BITS = NUM_CHAN * SYS_WDTH;
    localparam int unsigned HLD_WDTH = NUM_CHAN * DAT_WDTH;
    localparam int unsigned CNT_WDTH = $clog2(FRM_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_LAST} state_t;

    logic [2:0]          r_sck_sync;
    logic [1:0]          r_ws_sync;
    logic                r_ws_cap;
    state_t              r_state,   w_state_nxt;
    logic [FRM_BITS-1:0] r_shift,   w_shift_nxt;
    logic [CNT_WDTH-1:0] r_cnt,     w_cnt_nxt;
    logic [HLD_WDTH-1:0] r_hold,    w_hold_nxt;
    logic                r_ready,   w_ready_nxt;
    logic                r_sd,      w_sd_nxt;
    logic                r_uflow,   w_uflow_nxt;
    logic                r_ferr,    w_ferr_nxt;
    logic [FRM_BITS-1:0] w_frame_img;
    logic                w_sck_rise, w_sck_fall, w_frame_start;

    // Two-FF synchronisers plus a third sck stage for edge detection; ws latched on sck rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_ws_cap   <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], sck};
            r_ws_sync  <= {r_ws_sync[0], ws};
            if (w_sck_rise) r_ws_cap <= r_ws_sync[1];
        end
    end

    assign w_sck_rise    = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall    = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_frame_start = w_sck_rise & r_ws_cap & ~r_ws_sync[1];

    // Held frame laid out for MSB-first shifting: channel 0 on top, each slot sample then zero pad.
    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_slot
        assign w_frame_img[FRM_BITS-1-g*SYS_WDTH -: DAT_WDTH] = r_hold[g*DAT_WDTH +: DAT_WDTH];
        if (SYS_WDTH > DAT_WDTH) begin : g_pad
            assign w_frame_img[FRM_BITS-1-g*SYS_WDTH-DAT_WDTH -: (SYS_WDTH-DAT_WDTH)] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_ready <= 1'b1;
            r_sd    <= 1'b0;
            r_uflow <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_ready <= w_ready_nxt;
            r_sd    <= w_sd_nxt;
            r_uflow <= w_uflow_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_ready_nxt = r_ready;
        w_sd_nxt    = r_sd;
        w_uflow_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        if (w_frame_start) begin
            // A restart while still shifting means the master's frame was short.
            w_ferr_nxt  = (r_state == S_TX);
            w_state_nxt = S_TX;
            w_cnt_nxt   = '0;
            w_ready_nxt = 1'b1;
            w_shift_nxt = (mute || r_ready) ? '0 : w_frame_img;
            w_uflow_nxt = ~mute & r_ready;
        end else if (w_sck_fall) begin
            unique case (r_state)
                S_TX: begin
                    w_sd_nxt    = r_shift[FRM_BITS-1];
                    w_shift_nxt = {r_shift[FRM_BITS-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + CNT_WDTH'(1);
                    if (r_cnt == CNT_WDTH'(FRM_BITS - 1)) w_state_nxt = S_LAST;
                end
                S_LAST: begin
                    w_sd_nxt    = 1'b0;
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_sd_nxt = 1'b0;
            endcase
        end

        // Accept after any frame-start consumption so a held frame is loaded before being replaced.
        if (s_if.in_valid && r_ready) begin
            w_hold_nxt  = s_if.in_data;
            w_ready_nxt = 1'b0;
        end
    end

    assign sd            = r_sd;
    assign underflow     = r_uflow;
    assign frame_err     = r_ferr;
    assign s_if.in_ready = r_ready;

`ifdef I2S_TX_UFLOW_CNT_EN
    logic [15:0] r_uflow_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_uflow_cnt <= '0;
        else if (w_uflow_nxt && r_uflow_cnt != 16'hFFFF) r_uflow_cnt <= r_uflow_cnt + 16'd1;
    end

    assign uflow_cnt = r_uflow_cnt;
`endif
endmodule

// File: doc/i2s_tdm_slave_tx.md
I2S_TDM_SLAVE_TX -- requirements
Module: i2s_tdm_slave_tx

Interface
REQ-001 SHALL have parameter DAT_WDTH, default 24: sample width in bits.
REQ-002 SHALL have parameter SYS_WDTH, default 32: slot width in bits; DAT_WDTH <= SYS_WDTH.
REQ-003 SHALL have parameter NUM_CHAN, default 2: slots per frame; even, 2..8.
REQ-004 SHALL have port clk  input  1  system clock, the only clock; clk >= 4x sck.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sck  input  1  I2S bit clock, sampled as data.
REQ-007 SHALL have port ws  input  1  I2S word select or frame sync, sampled as data.
REQ-008 SHALL have port sd  output  1  serial data, registered.
REQ-009 SHALL have port in_data  input  NUM_CHAN*DAT_WDTH  frame; channel 0 in the least significant DAT_WDTH bits.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  holding register empty.
REQ-012 SHALL have port mute  input  1  force zero samples.
REQ-013 SHALL have port underflow  output  1  one-clk pulse.
REQ-014 SHALL have port frame_err  output  1  one-clk pulse.

Function
REQ-015 SHALL pass sck and ws through 2-FF synchronisers, then detect sck rise/fall with a third register.
REQ-016 SHALL capture synchronised ws on each detected sck rise; frame start = captured ws 1 then 0 on consecutive rises.
REQ-017 SHALL accept in_data into a one-entry holding register when in_valid && in_ready; in_ready = holding register empty.
REQ-018 At frame start: if holding full, SHALL load the shift register and empty the holding register; if empty, SHALL load zeros and pulse underflow.
REQ-019 Frame start and handshake in the same clk SHALL load the previously held frame and then accept the new one; in_ready SHALL stay 0 that cycle.
REQ-020 Shift register layout SHALL be channel 0 first; per slot, sample MSB-first, then SYS_WDTH-DAT_WDTH zero pad bits.
REQ-021 On the first sck fall after frame start, sd SHALL be the channel-0 MSB; each later fall SHALL drive the next bit (I2S one-bit delay).
REQ-022 After NUM_CHAN*SYS_WDTH bits, sd SHALL be 0 until the next frame start.
REQ-023 A frame start before all bits are sent SHALL pulse frame_err and restart at bit 0 with the new frame.
REQ-024 No frame start within one sck after the last bit SHALL pulse frame_err once; sd SHALL stay 0.
REQ-025 sd SHALL update within 4 clk after the sck pin falls and SHALL change only on detected sck falls.
REQ-026 mute sampled at frame start SHALL load zeros for that frame; the held frame SHALL still be consumed and no underflow pulse SHALL occur.

Reset
REQ-027 While rst is high: sd=0, underflow=0, frame_err=0, holding register empty (in_ready=1), bit counter idle, synchronisers 0.
REQ-028 After rst release, the first frame start SHALL NOT raise frame_err; bits SHALL be output only after a frame start.
REQ-029 rst mid-frame SHALL abort the frame immediately and discard the held frame.

Configuration
REQ-030 With I2S_TX_UFLOW_CNT_EN defined, the block SHALL add output uflow_cnt [15:0]: increments per underflow pulse, saturates at 16'hFFFF, resets to 0.
REQ-031 Without I2S_TX_UFLOW_CNT_EN, uflow_cnt and its counter SHALL be absent; all else unchanged.

Verification (DAT_WDTH=24, SYS_WDTH=32, NUM_CHAN=2, clk=8x sck)
REQ-032 in_data ch0=24'hA5A5A5, ch1=24'h123456 held before ws falls -> sd = A5A5A5, 8 zeros, 123456, 8 zeros, MSB on first fall after ws fall.
REQ-033 No in_valid before a frame start -> 64 zero bits, underflow pulses once, uflow_cnt=1 (macro on).
REQ-034 ws falls after bit 40 -> frame_err pulses, next sd bit = new frame channel-0 MSB.
REQ-035 in_valid held high for 3 frames -> in_ready 0 between loads, each frame is accepted once, no underflow.
REQ-036 rst pulse at bit 10 -> sd=0 and in_ready=1 at once; next frame after ws fall sends zeros and pulses underflow.
REQ-037 mute=1 at frame start with data held -> 64 zero bits, in_ready rises, no underflow.
